// File: rtl/mult_42_seq.sv
// Sequential unsigned multiplier: four partial-product rows per cycle are folded
// into a carry-save accumulator by two ranks of exact 4:2 compressors, then added.
module mult_42_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW     = 2 * WIDTH;
    localparam int GROUPS = WIDTH / 4;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMPRESS = 2'd1,
        ADD      = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_g;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [PW-1:0]   r_acc_sum;
    logic [PW-1:0]   r_acc_carry;
    logic [PW-1:0]   r_product;
    logic            r_in_ready;
    logic            r_out_valid;

    logic [3:0]      w_nib;
    logic [PW-1:0]   w_base;
    logic [PW-1:0]   w_pp [4];
    logic [PW-1:0]   w_s1, w_c1, w_s2, w_c2;

    // Exact 4:2 compressor row: the intermediate carry depends only on x1..x3,
    // so the lateral cin chain is one bit shift rather than a ripple.
    function automatic logic [2*PW-1:0] compress_4to2(
        input logic [PW-1:0] x1,
        input logic [PW-1:0] x2,
        input logic [PW-1:0] x3,
        input logic [PW-1:0] x4
    );
        logic [PW-1:0] t, co, ci, s, cy;
        t  = x1 ^ x2 ^ x3;
        co = (x1 & x2) | (x1 & x3) | (x2 & x3);
        ci = co << 1;
        s  = t ^ x4 ^ ci;
        cy = (t & x4) | (t & ci) | (x4 & ci);
        return {s, cy << 1};
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_nib  = 4'(r_b >> {r_g, 2'b00});
        w_base = {{WIDTH{1'b0}}, r_a} << {r_g, 2'b00};
        for (int i = 0; i < 4; i++) begin
            w_pp[i] = '0;
            if (w_nib[i]) w_pp[i] = w_base << i;
        end
    end

    assign {w_s1, w_c1} = compress_4to2(w_pp[0], w_pp[1], w_pp[2], w_pp[3]);
    assign {w_s2, w_c2} = compress_4to2(w_s1, w_c1, r_acc_sum, r_acc_carry);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_g         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc_sum   <= '0;
            r_acc_carry <= '0;
            r_product   <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_a         <= a;
                        r_b         <= b;
                        r_acc_sum   <= '0;
                        r_acc_carry <= '0;
                        r_g         <= '0;
                        r_in_ready  <= 1'b0;
                        r_state     <= COMPRESS;
                    end
                end
                COMPRESS: begin
                    r_acc_sum   <= w_s2;
                    r_acc_carry <= w_c2;
                    r_g         <= r_g + GW'(1);
                    if (r_g == G_LAST) r_state <= ADD;
                end
                ADD: begin
                    r_product   <= r_acc_sum + r_acc_carry;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;

endmodule
